// File: rtl/hs_npu_mem_arbiter_if.sv
// hs_npu_mem_arbiter_if: requester-side and memory-port signals of the NPU memory arbiter
interface hs_npu_mem_arbiter_if #(
  parameter int N_REQ = 3,
  parameter int WORDS = 2
);
  logic [N_REQ-1:0]                  req_valid_i;
  logic [N_REQ-1:0]                  req_write_i;
  logic [N_REQ-1:0][31:0]            req_addr_i;
  logic [N_REQ-1:0][WORDS-1:0][31:0] req_wdata_i;
  logic [N_REQ-1:0]                  req_ready_o;
  logic [N_REQ-1:0]                  rsp_valid_o;
  logic [WORDS-1:0][31:0]            rsp_rdata_o;
  logic                              rsp_err_o;
  logic                              mem_read_ready_o;
  logic                              mem_write_valid_o;
  logic                              mem_invalidate_o;
  logic [31:0]                       request_address_o;
  logic [WORDS-1:0][31:0]            memory_data_in_o;
  logic [WORDS-1:0][31:0]            memory_data_out_i;
  logic                              mem_ready_i;
  logic                              mem_valid_i;
  modport slave (
    input  req_valid_i, req_write_i, req_addr_i, req_wdata_i, memory_data_out_i, mem_ready_i, mem_valid_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, mem_read_ready_o, mem_write_valid_o,
           mem_invalidate_o, request_address_o, memory_data_in_o
  );
  modport master (
    output req_valid_i, req_write_i, req_addr_i, req_wdata_i, memory_data_out_i, mem_ready_i, mem_valid_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, mem_read_ready_o, mem_write_valid_o,
           mem_invalidate_o, request_address_o, memory_data_in_o
  );
endinterface

// File: rtl/hs_npu_mem_arbiter.sv
// hs_npu_mem_arbiter: round-robin arbiter/sequencer for hs_npu_memory_interface; HS_NPU_ARB_TIMEOUT_EN adds a watchdog abort
module hs_npu_mem_arbiter #(
  parameter int N_REQ   = 3,
  parameter int WORDS   = 2,
  parameter int TIMEOUT = 255
) (
  input logic clk,
  input logic rst,
  hs_npu_mem_arbiter_if.slave bus
);
  localparam int IW = $clog2(N_REQ);
  localparam int SW = IW + 1;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RD, WAIT_WR, ABORT} state_t;
  state_t                 state_q, state_d;
  logic [IW-1:0]          ptr_q, idx_q, win;
  logic [31:0]            addr_q;
  logic                   write_q, rd_done_q, grant, capture, timeout;
  logic [WORDS-1:0][31:0] wdata_q, rdata_q;
  logic [2*N_REQ-1:0]     dbl;
  logic [SW-1:0]          off, sum;
  assign grant   = state_q == IDLE && |bus.req_valid_i && bus.mem_ready_i && !rst;
  assign capture = state_q == WAIT_RD && !rd_done_q && bus.mem_valid_i;
  assign bus.rsp_rdata_o       = rdata_q;
  assign bus.request_address_o = addr_q;
  assign bus.memory_data_in_o  = wdata_q;
`ifdef HS_NPU_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1) > 8 ? $clog2(TIMEOUT + 1) : 8;
  logic [CW-1:0] cnt_q;
  assign timeout = cnt_q + 1'b1 == CW'(TIMEOUT);
  // watchdog: cleared on grant, counts every cycle a transaction is outstanding
  always_ff @(posedge clk) begin
    if (rst || grant || !(state_q == ISSUE || state_q == WAIT_RD || state_q == WAIT_WR)) cnt_q <= '0;
    else cnt_q <= cnt_q + 1'b1;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timeout = 1'b0;
`endif
  // round-robin winner: first pending requester at or above ptr, wrapping
  always_comb begin
    dbl = {bus.req_valid_i, bus.req_valid_i} >> ptr_q;
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) off = dbl[i] ? SW'(i) : off;
    sum = {1'b0, ptr_q} + off;
    win = sum >= SW'(N_REQ) ? IW'(sum - SW'(N_REQ)) : IW'(sum);
  end
  // transaction FSM next state and handshake outputs, all quiet during reset
  always_comb begin
    state_d               = state_q;
    bus.req_ready_o       = '0;
    bus.rsp_valid_o       = '0;
    bus.rsp_err_o         = 1'b0;
    bus.mem_read_ready_o  = 1'b0;
    bus.mem_write_valid_o = 1'b0;
    bus.mem_invalidate_o  = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          bus.req_ready_o = grant ? N_REQ'(1) << win : '0;
          state_d         = grant ? ISSUE : IDLE;
        end
        ISSUE: begin
          bus.mem_read_ready_o  = !write_q;
          bus.mem_write_valid_o = write_q;
          state_d = !bus.mem_ready_i ? (write_q ? WAIT_WR : WAIT_RD) : timeout ? ABORT : ISSUE;
        end
        WAIT_RD: begin
          bus.mem_read_ready_o = 1'b1;
          bus.rsp_valid_o      = rd_done_q ? N_REQ'(1) << idx_q : '0;
          state_d              = rd_done_q ? IDLE : timeout ? ABORT : WAIT_RD;
        end
        WAIT_WR: begin
          bus.rsp_valid_o = bus.mem_ready_i ? N_REQ'(1) << idx_q : '0;
          state_d         = bus.mem_ready_i ? IDLE : timeout ? ABORT : WAIT_WR;
        end
`ifdef HS_NPU_ARB_TIMEOUT_EN
        ABORT: begin
          bus.mem_invalidate_o = 1'b1;
          bus.rsp_valid_o      = N_REQ'(1) << idx_q;
          bus.rsp_err_o        = 1'b1;
          state_d              = IDLE;
        end
`endif
        default: state_d = IDLE;
      endcase
    end
  end
  // state, pointer, request latch and read-data capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      idx_q     <= '0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      rd_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_done_q <= capture;
      if (capture) rdata_q <= bus.memory_data_out_i;
      if (grant) begin
        ptr_q   <= win == IW'(N_REQ - 1) ? '0 : win + 1'b1;
        idx_q   <= win;
        addr_q  <= bus.req_addr_i[win];
        write_q <= bus.req_write_i[win];
        wdata_q <= bus.req_wdata_i[win];
      end
    end
  end
endmodule

// File: doc/hs_npu_mem_arbiter.md
# hs_npu_mem_arbiter

Round-robin arbiter and transaction sequencer in front of `hs_npu_memory_interface`. It shares the single memory port between N_REQ NPU requesters (weight fetch, activation fetch, result writeback). It latches one request at a time, drives the interface's read/write controls, and waits for completion. It then returns read data or a write acknowledge to the granted requester. An optional watchdog aborts hung transactions via `mem_invalidate`.

## Interface
- `N_REQ`, 3, number of requesters (2..8)
- `WORDS`, 2, 32-bit words per transaction (matches the interface data array size)
- `TIMEOUT`, 255, watchdog limit in cycles (used only with the watchdog compiled in)

Ports:
- `clk`  in  1  single clock
- `rst`  in  1  reset; synchronous and active-high, as already decided
- `req_valid_i`  in  N_REQ  request pending per requester; held until accepted
- `req_write_i`  in  N_REQ  1 = write, 0 = read
- `req_addr_i`  in  N_REQ×32  byte address per requester
- `req_wdata_i`  in  N_REQ×WORDS×32  write data per requester
- `req_ready_o`  out  N_REQ  one-hot, 1-cycle accept pulse
- `rsp_valid_o`  out  N_REQ  one-hot, 1-cycle completion pulse
- `rsp_rdata_o`  out  WORDS×32  read data, valid with `rsp_valid_o`
- `rsp_err_o`  out  1  completion was a watchdog abort
- `mem_read_ready_o`  out  1  to interface `mem_read_ready_i`
- `mem_write_valid_o`  out  1  to interface `mem_write_valid_i`
- `mem_invalidate_o`  out  1  to interface `mem_invalidate`
- `request_address_o`  out  32  to interface `request_address`
- `memory_data_in_o`  out  WORDS×32  write data to interface
- `memory_data_out_i`  in  WORDS×32  read data from interface
- `mem_ready_i`  in  1  interface idle/available
- `mem_valid_i`  in  1  interface read data valid pulse

## Operation
FSM states: IDLE, ISSUE, WAIT_RD, WAIT_WR, ABORT.
- **IDLE**
  - Waits until any `req_valid_i` is set and `mem_ready_i` = 1.
  - Picks the winner round-robin, searching upward from `ptr`.
  - Pulses `req_ready_o[winner]`.
  - Latches the winner's addr, write flag, wdata and index.
  - Sets `ptr` = winner+1, mod N_REQ. Goes to ISSUE.
- **ISSUE**
  - Drives `request_address_o` and `memory_data_in_o` from the latch.
  - Read: `mem_read_ready_o` = 1. Write: `mem_write_valid_o` = 1.
  - Holds until `mem_ready_i` = 0, which means the interface accepted the request.
  - Then goes to WAIT_RD or WAIT_WR.
- **WAIT_RD**
  - Keeps `mem_read_ready_o` = 1 so the interface can assert rready.
  - On `mem_valid_i`: captures `memory_data_out_i` into `rsp_rdata_o`.
  - Next cycle: pulses `rsp_valid_o[idx]`, then returns to IDLE.
- **WAIT_WR**
  - Deasserts `mem_write_valid_o`.
  - On `mem_ready_i` = 1: pulses `rsp_valid_o[idx]` and returns to IDLE.
- **ABORT** (watchdog only)
  - `mem_invalidate_o` = 1 for exactly one cycle.
  - Pulses `rsp_valid_o[idx]` with `rsp_err_o` = 1. Goes to IDLE.
- Requests are not pipelined: one transaction is outstanding at a time.
- Read and write requesters get equal priority; the only ordering rule is the round-robin pointer.
- `rsp_rdata_o` holds its last value until the next read completion. It is undefined (not cleared) for writes.
- A `req_valid_i` that drops before acceptance is ignored. Protocol requires holding it, but the arbiter must not break if it drops.

## Timing
- Reset values:
  - all `*_o` = 0, `rsp_rdata_o` = 0
  - state = IDLE, `ptr` = 0, watchdog counter = 0
- Reset mid-transaction returns to IDLE next cycle. No response is issued and `mem_invalidate_o` is not asserted.
- Accept latency: `req_ready_o` rises in the same cycle the request is seen in IDLE. Downstream controls assert from the next cycle.
- Read completion: `rsp_valid_o` is asserted 1 cycle after `mem_valid_i`.
- Write completion: `rsp_valid_o` is asserted in the cycle `mem_ready_i` returns high.
- Minimum gap between two grants is 3 cycles (IDLE→ISSUE→WAIT→IDLE).
- When a completion and a new request fall in the same cycle, the new request is granted on the following IDLE cycle. There is no bypass.
- `rsp_err_o` is valid only alongside `rsp_valid_o`; it is 0 otherwise.

## Configuration
- `HS_NPU_ARB_TIMEOUT_EN` defined:
  - An 8+ bit counter clears on entry to ISSUE and increments each cycle in ISSUE/WAIT_RD/WAIT_WR.
  - When it reaches TIMEOUT, the FSM goes to ABORT.
- Undefined:
  - No counter and no ABORT state.
  - `mem_invalidate_o` is tied to 0 and `rsp_err_o` is tied to 0.
  - The FSM waits indefinitely.

## Test plan
- Single read, requester 1, addr 0x100; model returns {0xA5A5_0001, 0xA5A5_0002} → `req_ready_o` = 3'b010, then `rsp_valid_o` = 3'b010 with that data and `rsp_err_o` = 0.
- Single write, requester 2, addr 0x200, data {1, 2} → `mem_write_valid_o` held until `mem_ready_i` = 0, addr 0x200 on the bus, and `rsp_valid_o` = 3'b100 when ready returns.
- All three requesters valid continuously for 6 transactions → grant order 0, 1, 2, 0, 1, 2. Each gets exactly 2 responses.
- Back-to-back: requester 0 re-asserts in the cycle it receives `rsp_valid_o` while requester 1 is waiting → requester 1 is granted next.
- Watchdog (macro on, TIMEOUT = 16): read whose `mem_valid_i` never arrives → `mem_invalidate_o` pulses 1 cycle after 16 cycles, with `rsp_valid_o` and `rsp_err_o` = 1. The next request completes normally.
- Reset asserted in WAIT_RD → outputs return to 0 next cycle, no `rsp_valid_o` is issued, and `ptr` = 0 (requester 0 wins the next grant).
